vram_loader_arb: RTL and testbench

VRAM_LOADER_ARB -- requirements
Module: vram_loader_arb

---
 rtl/vram_loader_arb.sv | 159 +++++++++++++++
 tb/tb_vram_loader_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_loader_arb.sv
// Video-RAM loader/arbiter: buffers HPS download bytes in a small FIFO and
// drains them into a single-port RAM whenever the video fetch path is idle.
module vram_loader_arb #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic              dl_busy,
  output logic              dl_done,
  output logic              dl_overflow,
  output logic              dl_range_err,
  output logic [ADDR_W:0]   dl_bytes
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   BYTES_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [26:0] addr_hi;
  logic        in_range;
  logic        wr_acc;
  logic        pop;
  logic        push;
  logic        drop;
  logic        range_hit;
  logic        start;
  logic        vld_p0, vld_p1;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == BYTES_MAX) ? v : v + {{ADDR_W{1'b0}}, 1'b1};
  endfunction

  assign addr_hi   = ioctl_addr >> ADDR_W;
  assign in_range  = (addr_hi == '0);
  assign wr_acc    = (state == LOAD) && ioctl_wr;
  // Video always wins the RAM port; the FIFO only drains on idle video cycles.
  assign pop       = (count != '0) && !vid_req;
  assign push      = wr_acc && in_range && ((count < DEPTH_C) || pop);
  assign drop      = wr_acc && in_range && !push;
  assign range_hit = wr_acc && !in_range;
  assign start     = (state == IDLE) && ioctl_download;

  assign dl_busy = (state != IDLE);
  assign dl_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ioctl_download)  state_nxt = LOAD;
      LOAD:    if (!ioctl_download) state_nxt = DRAIN;
      DRAIN:   if (count == '0)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ioctl_addr[ADDR_W-1:0];
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_overflow  <= 1'b0;
      dl_range_err <= 1'b0;
      dl_bytes     <= '0;
    end else if (start) begin
      dl_overflow  <= 1'b0;
      dl_range_err <= 1'b0;
      dl_bytes     <= '0;
    end else begin
      if (drop)      dl_overflow  <= 1'b1;
      if (range_hit) dl_range_err <= 1'b1;
      if (pop)       dl_bytes     <= sat_inc(dl_bytes);
    end
  end

  // Stage p0: RAM port arbitration (address/command registered toward the RAM)
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      vld_p0   <= 1'b0;
    end else if (vid_req) begin
      ram_addr <= vid_addr;
      ram_we   <= 1'b0;
      vld_p0   <= 1'b1;
    end else if (pop) begin
      ram_addr <= fifo_addr[rd_ptr];
      ram_din  <= fifo_data[rd_ptr];
      ram_we   <= 1'b1;
      vld_p0   <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      vld_p0   <= 1'b0;
    end
  end

  // Stage p1: RAM array access; Stage p2: capture read data for the video side
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1    <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      vld_p1    <= vld_p0;
      vid_valid <= vld_p1;
      if (vld_p1) vid_data <= ram_dout;
    end
  end

endmodule

// File: tb/tb_vram_loader_arb.sv
// Bench for vram_loader_arb: a queue-based reference model checked every cycle,
// plus directed download/video scenarios with literal expectations.
module tb_vram_loader_arb;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        dl_busy;
  logic        dl_done;
  logic        dl_overflow;
  logic        dl_range_err;
  logic [16:0] dl_bytes;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 0;

  vram_loader_arb #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .dl_busy(dl_busy), .dl_done(dl_done), .dl_overflow(dl_overflow),
    .dl_range_err(dl_range_err), .dl_bytes(dl_bytes)
  );

  always #5 clk_sys = ~clk_sys;

  // Power-up contents of a location that has never been written.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Single-port RAM, read data one cycle after the address.
  bit [7:0] ram_mem [65536];
  always @(posedge clk_sys) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din ^ pat(ram_addr);
    ram_dout <= ram_mem[ram_addr] ^ pat(ram_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] a; logic [7:0] d; } ent_t;
  typedef struct { int due; logic [7:0] d; } vrd_t;
  ent_t mq[$];
  vrd_t vq[$];
  bit [7:0] mmem [65536];
  bit       mw   [65536];
  int       m_phase;  // 0 idle, 1 load, 2 drain, 3 done
  int       m_cyc = 0;
  logic        e_we, e_vv;
  logic [15:0] e_addr;
  logic [7:0]  e_din, e_vd;
  logic        e_ovf, e_rng;
  logic [16:0] e_bytes;

  function automatic logic [7:0] mval(input logic [15:0] a);
    return mw[a] ? mmem[a] : pat(a);
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    int  n0;
    bit  pp;
    ent_t e;
    if (!reset_n) begin
      m_phase = 0;
      mq.delete();
      vq.delete();
      e_we = 0; e_addr = 0; e_din = 0; e_vv = 0; e_vd = 0;
      e_ovf = 0; e_rng = 0; e_bytes = 0;
    end else begin
      n0 = mq.size();
      pp = (n0 > 0) && !vid_req;
      if (m_phase == 0 && ioctl_download) begin
        e_ovf = 0; e_rng = 0; e_bytes = 0;
      end
      if (vid_req) begin
        e_we = 0;
        e_addr = vid_addr;
        vq.push_back('{due: m_cyc + 3, d: mval(vid_addr)});
      end else if (pp) begin
        e = mq.pop_front();
        e_we = 1; e_addr = e.a; e_din = e.d;
        mw[e.a] = 1; mmem[e.a] = e.d;
        if (e_bytes != 17'h1FFFF) e_bytes = e_bytes + 17'd1;
      end else begin
        e_we = 0;
      end
      if (m_phase == 1 && ioctl_wr) begin
        if (ioctl_addr >= 27'h10000) e_rng = 1;
        else if (n0 < 4 || pp) mq.push_back('{a: ioctl_addr[15:0], d: ioctl_dout});
        else e_ovf = 1;
      end
      case (m_phase)
        0: if (ioctl_download) m_phase = 1;
        1: if (!ioctl_download) m_phase = 2;
        2: if (n0 == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
      m_cyc++;
      e_vv = 0;
      if (vq.size() > 0 && vq[0].due == m_cyc) begin
        e_vv = 1;
        e_vd = vq[0].d;
        void'(vq.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  logic [23:0] wlog[$];
  int tcyc = 0, last_we_cyc = -1, done_cnt = 0, done_cyc = -1;
  int req_cyc = -1, vv_cyc = -1;
  logic [7:0] vv_data = 8'h00;

  always @(negedge clk_sys) begin
    tcyc++;
    if (cmp_en) begin
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_din", ram_din, e_din);
      chk("vid_valid", vid_valid, e_vv);
      chk("vid_data", vid_data, e_vd);
      chk("dl_busy", dl_busy, m_phase != 0);
      chk("dl_done", dl_done, m_phase == 3);
      chk("dl_overflow", dl_overflow, e_ovf);
      chk("dl_range_err", dl_range_err, e_rng);
      chk("dl_bytes", dl_bytes, e_bytes);
    end
    if (ram_we === 1'b1) begin
      wlog.push_back({ram_addr, ram_din});
      last_we_cyc = tcyc;
    end
    if (dl_done === 1'b1) begin
      done_cnt++;
      done_cyc = tcyc;
    end
    if (vid_req) req_cyc = tcyc;
    if (vid_valid === 1'b1) begin
      vv_cyc = tcyc;
      vv_data = vid_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    tick(1);
    ioctl_wr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
    vid_req = 0; vid_addr = 0;
    tick(2);
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_din", ram_din, 0);
    chk("rst vid_valid", vid_valid, 0);
    chk("rst vid_data", vid_data, 0);
    chk("rst dl_busy", dl_busy, 0);
    chk("rst dl_done", dl_done, 0);
    chk("rst dl_overflow", dl_overflow, 0);
    chk("rst dl_range_err", dl_range_err, 0);
    chk("rst dl_bytes", dl_bytes, 0);
    cmp_en = 1;
    reset_n = 1;
    tick(2);

    // Three-byte download, no video traffic
    wlog.delete(); done_cnt = 0;
    ioctl_download = 1; tick(1);
    for (int i = 0; i < 3; i++) wr_byte(27'(i), 8'(8'h11 * (i + 1)));
    ioctl_download = 0;
    tick(8);
    chk("A writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("A w0", wlog[0], 24'h0000_11);
      chk("A w1", wlog[1], 24'h0001_22);
      chk("A w2", wlog[2], 24'h0002_33);
    end
    chk("A dl_bytes", dl_bytes, 3);
    chk("A done pulses", done_cnt, 1);
    chk("A done timing", done_cyc, last_we_cyc + 1);
    chk("A busy after", dl_busy, 0);

    // Video held for 10 cycles while 6 bytes arrive back-to-back
    wlog.delete();
    vid_req = 1; vid_addr = 16'h0000; ioctl_download = 1; tick(1);
    for (int i = 0; i < 6; i++) begin
      vid_addr = 16'(i);
      wr_byte(27'h100 + 27'(i), 8'hC0 + 8'(i));
    end
    tick(3);
    vid_req = 0; ioctl_download = 0;
    tick(1);
    chk("B writes during video", wlog.size(), 0);
    tick(10);
    chk("B writes after", wlog.size(), 4);
    if (wlog.size() == 4)
      for (int i = 0; i < 4; i++) chk("B wr", wlog[i], {16'h0100 + 16'(i), 8'hC0 + 8'(i)});
    chk("B overflow", dl_overflow, 1);
    chk("B dl_bytes", dl_bytes, 4);

    // Strobes outside a download are ignored
    wlog.delete();
    wr_byte(27'h200, 8'h99);
    wr_byte(27'h10000, 8'h98);
    tick(3);
    chk("C writes", wlog.size(), 0);
    chk("C overflow kept", dl_overflow, 1);
    chk("C range_err kept", dl_range_err, 0);
    chk("C dl_bytes kept", dl_bytes, 4);

    // Read-after-write with fixed 3-cycle latency
    ioctl_download = 1; tick(1);
    wr_byte(27'h10, 8'hA5);
    ioctl_download = 0;
    tick(6);
    chk("D dl_bytes", dl_bytes, 1);
    chk("D overflow cleared", dl_overflow, 0);
    vid_req = 1; vid_addr = 16'h0010; tick(1);
    vid_req = 0; tick(5);
    chk("D latency", vv_cyc, req_cyc + 3);
    chk("D vid_data", vv_data, 8'hA5);

    // Out-of-range address
    wlog.delete();
    ioctl_download = 1; tick(1);
    wr_byte(27'h20, 8'h44);
    wr_byte(27'h10000, 8'h77);
    ioctl_download = 0;
    tick(6);
    chk("E range_err", dl_range_err, 1);
    chk("E dl_bytes", dl_bytes, 1);
    chk("E writes", wlog.size(), 1);
    if (wlog.size() == 1) chk("E w0", wlog[0], 24'h0020_44);
    ioctl_download = 1; tick(2);
    chk("E range_err cleared", dl_range_err, 0);
    chk("E busy", dl_busy, 1);
    chk("E bytes cleared", dl_bytes, 0);
    ioctl_download = 0; tick(4);

    // Reset with three entries buffered
    vid_req = 1; vid_addr = 16'h0005; ioctl_download = 1; tick(1);
    for (int i = 0; i < 3; i++) wr_byte(27'h30 + 27'(i), 8'hD0 + 8'(i));
    tick(1);
    reset_n = 0; vid_req = 0; ioctl_download = 0;
    wlog.delete();
    #1;
    chk("F ram_we in reset", ram_we, 0);
    chk("F busy in reset", dl_busy, 0);
    chk("F bytes in reset", dl_bytes, 0);
    tick(2);
    reset_n = 1;
    tick(8);
    chk("F writes after release", wlog.size(), 0);
    chk("F busy after release", dl_busy, 0);
    vid_req = 1; vid_addr = 16'h0030; tick(1);
    vid_req = 0; tick(5);
    chk("F unwritten read", vv_data, 8'h6A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
